// File: rtl/ysyx_25040105_ifu_if.sv
// Fetch-unit bundle: instruction-memory request/response, decode handoff and execute redirect.
// The master modport is the fetch unit's view; slave is the surrounding pipeline/memory.
interface ysyx_25040105_ifu_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_err;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst, inst_pc,
        input  inst_ready,
        input  redirect_valid, redirect_pc,
        output fetch_err
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst, inst_pc,
        output inst_ready,
        output redirect_valid, redirect_pc,
        input  fetch_err
    );
endinterface

// File: rtl/ysyx_25040105_ifu.sv
// Instruction fetch unit: owns the PC, keeps one imem read in flight, holds the word for decode.
// Define IFU_ALIGN_CHECK_EN to trap misaligned redirect targets into a sticky error state.
module ysyx_25040105_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    ysyx_25040105_ifu_if.master  bus
);
    localparam int unsigned XLEN = 32;

`ifdef IFU_ALIGN_CHECK_EN
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_ERR} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;
`endif

    state_t            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   inst_q, inst_d;
    logic              drop_q, drop_d;
    logic              fetch_err_q, fetch_err_d;
    logic              req_valid_q;
    logic              inst_valid_q;
    logic [XLEN-1:0]   redir_tgt;

`ifdef IFU_ALIGN_CHECK_EN
    logic redir_bad;
    assign redir_tgt = bus.redirect_pc;
    assign redir_bad = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
`else
    // Low target bits are architecturally meaningless here, so they are simply cleared.
    logic unused_redir_lsb;
    assign redir_tgt        = {bus.redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redir_lsb = ^bus.redirect_pc[1:0];
`endif

    // Next-state and datapath update; redirect outranks every other event.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        drop_d      = drop_q;
        fetch_err_d = fetch_err_q;

        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (bus.redirect_valid) begin
                    pc_d = redir_tgt;
                    if (bus.imem_req_ready) begin
                        drop_d  = 1'b1;
                        state_d = S_WAIT;
                    end
                end else if (bus.imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.redirect_valid) begin
                    pc_d = redir_tgt;
                    if (bus.imem_rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (bus.imem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                    end else begin
                        inst_d  = bus.imem_rsp_data;
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (bus.redirect_valid) begin
                    pc_d    = redir_tgt;
                    state_d = S_REQ;
                end else if (bus.inst_ready) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = S_REQ;
                end
            end
`ifdef IFU_ALIGN_CHECK_EN
            S_ERR: state_d = S_ERR;
`endif
            default: state_d = S_IDLE;
        endcase

`ifdef IFU_ALIGN_CHECK_EN
        if (redir_bad && (state_q == S_REQ || state_q == S_WAIT || state_q == S_HOLD)) begin
            pc_d        = redir_tgt;
            drop_d      = 1'b0;
            fetch_err_d = 1'b1;
            state_d     = S_ERR;
        end
`endif
    end

    // State and registered outputs; valids are decoded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            drop_q       <= 1'b0;
            fetch_err_q  <= 1'b0;
            req_valid_q  <= 1'b0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            drop_q       <= drop_d;
            fetch_err_q  <= fetch_err_d;
            req_valid_q  <= (state_d == S_REQ);
            inst_valid_q <= (state_d == S_HOLD);
        end
    end

    assign bus.imem_req_valid = req_valid_q;
    assign bus.imem_req_addr  = pc_q;
    assign bus.inst_valid     = inst_valid_q;
    assign bus.inst           = inst_q;
    assign bus.inst_pc        = pc_q;
    assign bus.fetch_err      = fetch_err_q;
endmodule

// File: tb/tb_ysyx_25040105_ifu.sv
// Bench for the fetch unit: directed scenarios plus a randomized run against a transaction-level model.
module tb_ysyx_25040105_ifu;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    ysyx_25040105_ifu_if bus ();
    ysyx_25040105_ifu #(.RESET_PC(RESET_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_valid"}, 32'(bus.imem_req_valid), 32'd0);
        check({tag, "_req_addr"},  bus.imem_req_addr, RESET_PC);
        check({tag, "_inst_valid"}, 32'(bus.inst_valid), 32'd0);
        check({tag, "_inst"},      bus.inst, 32'h0);
        check({tag, "_inst_pc"},   bus.inst_pc, RESET_PC);
        check({tag, "_fetch_err"}, 32'(bus.fetch_err), 32'd0);
    endtask

    // Reference model state for the random run: architectural pc, one outstanding read, held word.
    logic [31:0] exp_pc, exp_inst, tgt;
    logic        outstanding, live, hold, redir, rsp;
    int          rsp_cnt, deliveries;

    initial begin
        drive_idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("reset");

        // Basic fetch with zero-wait memory, then decode back-pressure.
        rst = 1'b0;
        @(negedge clk);
        check("t1_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("t1_req_addr", bus.imem_req_addr, 32'h8000_0000);
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        check("t1_wait_req_valid", 32'(bus.imem_req_valid), 32'd0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h0000_0413;
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("t2_inst_valid", 32'(bus.inst_valid), 32'd1);
            check("t2_inst", bus.inst, 32'h0000_0413);
            check("t2_inst_pc", bus.inst_pc, 32'h8000_0000);
            check("t2_no_req", 32'(bus.imem_req_valid), 32'd0);
            @(negedge clk);
        end
        bus.inst_ready = 1'b1;
        check("t2_inst_valid_last", 32'(bus.inst_valid), 32'd1);
        @(negedge clk);
        bus.inst_ready = 1'b0;
        check("t2_inst_valid_drop", 32'(bus.inst_valid), 32'd0);
        check("t2_next_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("t2_next_addr", bus.imem_req_addr, 32'h8000_0004);

        // Memory stalls the request for three cycles; handshake on the fourth.
        for (int i = 0; i < 3; i++) begin
            check("t3_stall_valid", 32'(bus.imem_req_valid), 32'd1);
            check("t3_stall_addr", bus.imem_req_addr, 32'h8000_0004);
            @(negedge clk);
        end
        check("t3_hs_valid", 32'(bus.imem_req_valid), 32'd1);
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        check("t3_wait_valid", 32'(bus.imem_req_valid), 32'd0);

        // Redirect while waiting: the late response must be thrown away.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0100;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        check("t4_wait_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("t4_wait_inst_valid", 32'(bus.inst_valid), 32'd0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        check("t4_dropped_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("t4_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("t4_req_addr", bus.imem_req_addr, 32'h8000_0100);

        // Redirect and decode accept in the same cycle: target wins over pc+4.
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h1234_5678;
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        check("t5_inst_valid", 32'(bus.inst_valid), 32'd1);
        check("t5_inst", bus.inst, 32'h1234_5678);
        check("t5_inst_pc", bus.inst_pc, 32'h8000_0100);
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0040;
        @(negedge clk);
        drive_idle();
        check("t5_inst_valid_drop", 32'(bus.inst_valid), 32'd0);
        check("t5_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("t5_req_addr", bus.imem_req_addr, 32'h8000_0040);

        // Randomized run against the transaction-level model.
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_pc      = RESET_PC;
        exp_inst    = 32'h0;
        outstanding = 1'b0;
        live        = 1'b0;
        hold        = 1'b0;
        rsp_cnt     = 0;
        deliveries  = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            check("rnd_req_valid", 32'(bus.imem_req_valid), 32'(!(outstanding || hold)));
            if (!(outstanding || hold))
                check("rnd_req_addr", bus.imem_req_addr, exp_pc);
            check("rnd_inst_valid", 32'(bus.inst_valid), 32'(hold));
            if (hold) begin
                check("rnd_inst", bus.inst, exp_inst);
                check("rnd_inst_pc", bus.inst_pc, exp_pc);
            end
            check("rnd_fetch_err", 32'(bus.fetch_err), 32'd0);

            bus.imem_req_ready = ($urandom_range(2) != 0);
            bus.inst_ready     = 1'($urandom_range(1));
            redir              = ($urandom_range(7) == 0);
            bus.redirect_valid = redir;
            bus.redirect_pc    = ($urandom_range(3) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            rsp = 1'b0;
            if (outstanding) begin
                if (rsp_cnt == 0) rsp = 1'b1;
                else rsp_cnt--;
            end else begin
                rsp = ($urandom_range(5) == 0);
            end
            bus.imem_rsp_valid = rsp;
            bus.imem_rsp_data  = $urandom();
            tgt = bus.redirect_pc;

            if (hold) begin
                if (redir) begin
                    exp_pc = tgt;
                    hold   = 1'b0;
                end else if (bus.inst_ready) begin
                    exp_pc = exp_pc + 32'd4;
                    hold   = 1'b0;
                    deliveries++;
                end
            end else if (outstanding) begin
                if (rsp) begin
                    outstanding = 1'b0;
                    if (live && !redir) begin
                        hold     = 1'b1;
                        exp_inst = bus.imem_rsp_data;
                    end
                end
                if (redir) begin
                    exp_pc = tgt;
                    live   = 1'b0;
                end
            end else begin
                if (bus.imem_req_ready) begin
                    outstanding = 1'b1;
                    live        = !redir;
                    rsp_cnt     = $urandom_range(3);
                end
                if (redir) exp_pc = tgt;
            end
            @(negedge clk);
        end
        check("rnd_deliveries_seen", 32'(deliveries > 20), 32'd1);

        // Reset in mid-flight, with a stale response arriving just after release.
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        rst = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hBAD0_BAD0;
        @(negedge clk);
        check("midrst_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("midrst_req_addr", bus.imem_req_addr, RESET_PC);
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        check("midrst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("midrst_req_valid2", 32'(bus.imem_req_valid), 32'd1);

        // Misaligned redirect target.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h8000_0102;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
        bus.imem_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t6_fetch_err", 32'(bus.fetch_err), 32'd1);
            check("t6_no_req", 32'(bus.imem_req_valid), 32'd0);
            check("t6_no_inst", 32'(bus.inst_valid), 32'd0);
            bus.redirect_valid = (i == 1);
            bus.redirect_pc    = 32'h8000_0200;
            @(negedge clk);
        end
        check("t6_fetch_err_sticky", 32'(bus.fetch_err), 32'd1);
`else
        check("t6_fetch_err", 32'(bus.fetch_err), 32'd0);
        check("t6_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("t6_req_addr", bus.imem_req_addr, 32'h8000_0100);
`endif
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        check("final_fetch_err", 32'(bus.fetch_err), 32'd0);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
